// File: rtl/xmega_link_rx.sv
// Xmega CM/CLK_inter receiver: sync, beat packing, FWFT FIFO with valid/ready.
// Optional partial-word idle timeout enabled by defining XLINK_TIMEOUT_EN.
module xmega_link_rx #(
  parameter int CM_WIDTH = 8,
  parameter int BEATS    = 2,
  parameter int DEPTH    = 4,
  parameter int TIMEOUT  = 1024
) (
  input  logic                         CLK_50,
  input  logic                         RST,
  input  logic [CM_WIDTH-1:0]          CM,
  input  logic                         CLK_inter,
  output logic [CM_WIDTH*BEATS-1:0]    DOUT,
  output logic                         DOUT_VALID,
  input  logic                         DOUT_READY,
  output logic [$clog2(DEPTH+1)-1:0]   LEVEL,
  output logic                         OVERFLOW,
  input  logic                         CLR_OVF,
  output logic                         DROPPED
);

  localparam int W  = CM_WIDTH * BEATS;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH + 1);
  localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;

  logic                s1_q, s2_q, s3_q;
  logic [CM_WIDTH-1:0] cm1_q, cm2_q;
  logic                w1_q, w2_q;
  logic                arm_q, arm_d;
  logic                stb_edge;

  logic [BW-1:0]       beat_q, beat_d;
  logic [W-1:0]        part_q, part_d;
  logic                push_q, push_d;
  logic [W-1:0]        pword_q, pword_d;

  logic [W-1:0]        mem_q [DEPTH];
  logic [AW-1:0]       wr_q, wr_d;
  logic [AW-1:0]       rd_q, rd_d;
  logic [LW-1:0]       lvl_q, lvl_d;
  logic [W-1:0]        dout_q, dout_d;
  logic                dval_q, dval_d;
  logic                ovf_q, ovf_d;
  logic                pop, full, wr_en, ovf_set;

`ifdef XLINK_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0]       idle_q, idle_d;
  logic                drop_q, drop_d;
`endif

  // w1/w2 mark when s2 holds a real post-reset sample of CLK_inter,
  // so a strobe held high through reset never arms the detector.
  always_ff @(posedge CLK_50) begin
    if (RST) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      s3_q  <= 1'b0;
      cm1_q <= '0;
      cm2_q <= '0;
      w1_q  <= 1'b0;
      w2_q  <= 1'b0;
    end else begin
      s1_q  <= CLK_inter;
      s2_q  <= s1_q;
      s3_q  <= s2_q;
      cm1_q <= CM;
      cm2_q <= cm1_q;
      w1_q  <= 1'b1;
      w2_q  <= w1_q;
    end
  end

  always_comb begin
    stb_edge = arm_q & s2_q & ~s3_q;
    arm_d    = arm_q | (w2_q & ~s2_q);
    beat_d   = beat_q;
    part_d   = part_q;
    push_d   = 1'b0;
    pword_d  = pword_q;
`ifdef XLINK_TIMEOUT_EN
    idle_d   = '0;
    drop_d   = 1'b0;
`endif
    if (stb_edge) begin
      for (int b = 0; b < BEATS; b++) begin
        if (beat_q == BW'(b)) part_d[b*CM_WIDTH +: CM_WIDTH] = cm2_q;
      end
      if (beat_q == BW'(BEATS - 1)) begin
        beat_d  = '0;
        pword_d = part_d;
        part_d  = '0;
        push_d  = 1'b1;
      end else begin
        beat_d  = beat_q + BW'(1);
      end
    end
`ifdef XLINK_TIMEOUT_EN
    else if (beat_q != '0) begin
      if (idle_q == TW'(TIMEOUT - 1)) begin
        beat_d = '0;
        part_d = '0;
        drop_d = 1'b1;
      end else begin
        idle_d = idle_q + TW'(1);
      end
    end
`endif
  end

  always_comb begin
    pop     = dval_q & DOUT_READY;
    full    = (lvl_q == LW'(DEPTH));
    wr_en   = push_q & (~full | pop);
    ovf_set = push_q & full & ~pop;
    wr_d    = wr_en ? wr_q + AW'(1) : wr_q;
    rd_d    = pop ? rd_q + AW'(1) : rd_q;
    lvl_d   = lvl_q;
    unique case (1'b1)
      (wr_en & ~pop): lvl_d = lvl_q + LW'(1);
      (pop & ~wr_en): lvl_d = lvl_q - LW'(1);
      default:        lvl_d = lvl_q;
    endcase
    // Output register only sees words already in memory before this edge,
    // which gives the one-cycle push-to-DOUT latency.
    dval_d  = pop ? (lvl_q > LW'(1)) : (lvl_q != '0);
    dout_d  = dval_d ? mem_q[rd_d] : dout_q;
    ovf_d   = ovf_set | (ovf_q & ~CLR_OVF);
  end

  always_ff @(posedge CLK_50) begin
    if (RST) begin
      arm_q   <= 1'b0;
      beat_q  <= '0;
      part_q  <= '0;
      push_q  <= 1'b0;
      pword_q <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      lvl_q   <= '0;
      dout_q  <= '0;
      dval_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      arm_q   <= arm_d;
      beat_q  <= beat_d;
      part_q  <= part_d;
      push_q  <= push_d;
      pword_q <= pword_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      lvl_q   <= lvl_d;
      dout_q  <= dout_d;
      dval_q  <= dval_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge CLK_50) begin
    if (wr_en) mem_q[wr_q] <= pword_q;
  end

`ifdef XLINK_TIMEOUT_EN
  always_ff @(posedge CLK_50) begin
    if (RST) begin
      idle_q <= '0;
      drop_q <= 1'b0;
    end else begin
      idle_q <= idle_d;
      drop_q <= drop_d;
    end
  end

  assign DROPPED = drop_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT > 0);
  assign DROPPED        = 1'b0;
`endif

  assign DOUT       = dout_q;
  assign DOUT_VALID = dval_q;
  assign LEVEL      = lvl_q;
  assign OVERFLOW   = ovf_q;

endmodule

// File: tb/tb_xmega_link_rx.sv
// Scoreboard bench for xmega_link_rx (CM_WIDTH=8, BEATS=2, DEPTH=4, TIMEOUT=16).
module tb_xmega_link_rx;

  logic        clk = 1'b0;
  logic        RST = 1'b1;
  logic [7:0]  CM = '0;
  logic        CLK_inter = 1'b0;
  logic [15:0] DOUT;
  logic        DOUT_VALID;
  logic        DOUT_READY = 1'b0;
  logic [2:0]  LEVEL;
  logic        OVERFLOW;
  logic        CLR_OVF = 1'b0;
  logic        DROPPED;

  int          n_tests = 0;
  int          n_fail = 0;
  int          drop_cnt = 0;
  logic [15:0] last_word = '0;
  logic [15:0] exp_q[$];

  xmega_link_rx #(
    .CM_WIDTH(8), .BEATS(2), .DEPTH(4), .TIMEOUT(16)
  ) dut (
    .CLK_50(clk), .RST(RST), .CM(CM), .CLK_inter(CLK_inter),
    .DOUT(DOUT), .DOUT_VALID(DOUT_VALID), .DOUT_READY(DOUT_READY),
    .LEVEL(LEVEL), .OVERFLOW(OVERFLOW), .CLR_OVF(CLR_OVF),
    .DROPPED(DROPPED)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (DROPPED) drop_cnt++;
    if (!RST && DOUT_VALID && DOUT_READY) begin
      int qs;
      qs = exp_q.size();
      if (qs == 0) chk("sb_unexpected", 32'(qs), 32'd1);
      else begin
        last_word = DOUT;
        chk("sb_word", 32'(DOUT), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [7:0] v, input bit rdy_push);
    CM = v;
    cyc(1);
    CLK_inter = 1'b1;
    cyc(3);
    if (rdy_push) DOUT_READY = 1'b1;
    cyc(1);
    if (rdy_push) DOUT_READY = 1'b0;
    CLK_inter = 1'b0;
    cyc(4);
  endtask

  task automatic send_word(input logic [15:0] w, input bit keep);
    if (keep) exp_q.push_back(w);
    beat(w[7:0], 1'b0);
    beat(w[15:8], 1'b0);
  endtask

  task automatic drain();
    DOUT_READY = 1'b1;
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) cyc(1);
    cyc(2);
    DOUT_READY = 1'b0;
    chk("drain_left", 32'(exp_q.size()), 32'd0);
    chk("drain_level", 32'(LEVEL), 32'd0);
    chk("drain_valid", 32'(DOUT_VALID), 32'd0);
  endtask

  task automatic do_reset(input int n);
    RST = 1'b1;
    cyc(n);
    RST = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc(3);
    RST = 1'b0;
    chk("rst_dout", 32'(DOUT), 32'h0);
    chk("rst_valid", 32'(DOUT_VALID), 32'h0);
    chk("rst_level", 32'(LEVEL), 32'h0);
    chk("rst_ovf", 32'(OVERFLOW), 32'h0);
    chk("rst_drop", 32'(DROPPED), 32'h0);
    cyc(5);

    // 1: basic word and latency
    beat(8'h34, 1'b0);
    exp_q.push_back(16'h1234);
    CM = 8'h12;
    cyc(1);
    CLK_inter = 1'b1;
    cyc(4);
    chk("t1_lvl_push", 32'(LEVEL), 32'd1);
    chk("t1_val_early", 32'(DOUT_VALID), 32'd0);
    cyc(1);
    chk("t1_dout", 32'(DOUT), 32'h1234);
    chk("t1_valid", 32'(DOUT_VALID), 32'd1);
    chk("t1_level", 32'(LEVEL), 32'd1);
    CLK_inter = 1'b0;
    DOUT_READY = 1'b1;
    cyc(1);
    DOUT_READY = 1'b0;
    chk("t1_pop_valid", 32'(DOUT_VALID), 32'd0);
    chk("t1_pop_level", 32'(LEVEL), 32'd0);
    cyc(3);

    // 2: overflow
    for (int i = 1; i <= 5; i++) send_word({2{8'(i)}}, i != 5);
    chk("t2_level", 32'(LEVEL), 32'd4);
    chk("t2_ovf", 32'(OVERFLOW), 32'd1);
    chk("t2_head", 32'(DOUT), 32'h0101);
    drain();
    chk("t2_ovf_sticky", 32'(OVERFLOW), 32'd1);
    CLR_OVF = 1'b1;
    cyc(1);
    CLR_OVF = 1'b0;
    chk("t2_ovf_clr", 32'(OVERFLOW), 32'd0);

    // 3: push and pop together at full
    for (int i = 1; i <= 4; i++) send_word({2{8'(i)}}, 1'b1);
    chk("t3_full", 32'(LEVEL), 32'd4);
    exp_q.push_back(16'h0606);
    beat(8'h06, 1'b0);
    beat(8'h06, 1'b1);
    chk("t3_ovf", 32'(OVERFLOW), 32'd0);
    chk("t3_level", 32'(LEVEL), 32'd4);
    drain();
    chk("t3_last", 32'(last_word), 32'h0606);

    // 4: idle partial word
    drop_cnt = 0;
    beat(8'hAA, 1'b0);
    cyc(20);
`ifdef XLINK_TIMEOUT_EN
    chk("t4_drops", 32'(drop_cnt), 32'd1);
    send_word(16'h2211, 1'b1);
    chk("t4_dout", 32'(DOUT), 32'h2211);
`else
    chk("t4_drops", 32'(drop_cnt), 32'd0);
    exp_q.push_back(16'hBBAA);
    beat(8'hBB, 1'b0);
    chk("t4_dout", 32'(DOUT), 32'hBBAA);
`endif
    drain();

    // 5: strobe held high through reset
    CLK_inter = 1'b1;
    CM = 8'h55;
    do_reset(2);
    cyc(10);
    chk("t5_level", 32'(LEVEL), 32'd0);
    chk("t5_valid", 32'(DOUT_VALID), 32'd0);
    CLK_inter = 1'b0;
    cyc(4);
    send_word(16'h7766, 1'b1);
    chk("t5_dout", 32'(DOUT), 32'h7766);
    drain();

    // 6: reset mid-word with data buffered
    send_word(16'hA1B2, 1'b1);
    send_word(16'hC3D4, 1'b1);
    beat(8'h99, 1'b0);
    chk("t6_level_pre", 32'(LEVEL), 32'd2);
    do_reset(1);
    chk("t6_level", 32'(LEVEL), 32'd0);
    chk("t6_valid", 32'(DOUT_VALID), 32'd0);
    cyc(5);
    send_word(16'h0201, 1'b1);
    chk("t6_dout", 32'(DOUT), 32'h0201);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
